// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: byte-command sequencer for the adaptive FIR filter.
// Ports: clk/reset (sync, active-high); cmd_data/cmd_valid/cmd_ready host
// byte stream; fir_x_n/fir_tvalid/fir_set_coeffs drive the FIR; fir_y_n is
// the FIR result; y_out/y_valid deliver one result per counted sample;
// busy is low only in IDLE.
module fir_stream_ctrl #(
    parameter int X_N_SIZE    = 8,
    parameter int Y_N_SIZE    = 14,
    parameter int NBR_OF_TAPS = 10,
    parameter int INIT_CYCLES = 4,
    parameter int PIPE_LAT    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          cmd_data,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic [X_N_SIZE-1:0] fir_x_n,
    output logic                fir_tvalid,
    output logic                fir_set_coeffs,
    input  logic [Y_N_SIZE-1:0] fir_y_n,
    output logic [Y_N_SIZE-1:0] y_out,
    output logic                y_valid,
    output logic                busy
);

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        COEF,
        STREAM,
        FLUSH,
        DRAIN
    } state_t;

    localparam int CW = 16;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [5:0]          rem, rem_n;
    logic [X_N_SIZE-1:0] x_n;
    logic                tv_n;
    logic                sc_n;
    logic                tag_n;
    logic                ready_n;
    logic                busy_n;
    logic                acc;
    logic [1:0]          op;
    logic [5:0]          len;

    // tags[0] travels alongside fir_x_n; tags[PIPE_LAT] lines up with the
    // FIR result of that sample on fir_y_n.
    logic [PIPE_LAT:0]   tags;

    assign acc = cmd_valid && cmd_ready;
    assign op  = cmd_data[7:6];
    assign len = cmd_data[5:0];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        x_n     = fir_x_n;
        tv_n    = 1'b0;
        sc_n    = 1'b0;
        tag_n   = 1'b0;
        case (state)
            WAIT_INIT: begin
                if (cnt == CW'(INIT_CYCLES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (acc) begin
                    case (op)
                        2'b01: begin
                            if (len != 6'd0) begin
                                state_n = COEF;
                                rem_n   = len;
                            end
                        end
                        2'b10: begin
                            if (len != 6'd0) begin
                                state_n = STREAM;
                                rem_n   = len;
                            end
                        end
                        2'b11: begin
                            state_n = FLUSH;
                            cnt_n   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            COEF: begin
                if (acc) begin
                    x_n   = X_N_SIZE'(cmd_data);
                    sc_n  = 1'b1;
                    rem_n = rem - 1'b1;
                    if (rem == 6'd1)
                        state_n = IDLE;
                end
            end
            STREAM: begin
                tv_n = 1'b1;
                if (acc) begin
                    x_n   = X_N_SIZE'(cmd_data);
                    tag_n = 1'b1;
                    rem_n = rem - 1'b1;
                    if (rem == 6'd1) begin
                        state_n = DRAIN;
                        cnt_n   = '0;
                    end
                end else begin
                    // stall: feed a zero that produces no host result
                    x_n = '0;
                end
            end
            FLUSH: begin
                tv_n  = 1'b1;
                x_n   = '0;
                tag_n = 1'b1;
                if (cnt == CW'(NBR_OF_TAPS - 1)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DRAIN: begin
                tv_n = 1'b1;
                x_n  = '0;
                if (cnt == CW'(PIPE_LAT - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = WAIT_INIT;
                cnt_n   = '0;
            end
        endcase
        ready_n = (state_n == IDLE) || (state_n == COEF) ||
                  (state_n == STREAM);
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_INIT;
            cnt            <= '0;
            rem            <= '0;
            fir_x_n        <= '0;
            fir_tvalid     <= 1'b0;
            fir_set_coeffs <= 1'b0;
            cmd_ready      <= 1'b0;
            busy           <= 1'b1;
            tags           <= '0;
            y_out          <= '0;
            y_valid        <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            rem            <= rem_n;
            fir_x_n        <= x_n;
            fir_tvalid     <= tv_n;
            fir_set_coeffs <= sc_n;
            cmd_ready      <= ready_n;
            busy           <= busy_n;
            tags           <= {tags[PIPE_LAT-1:0], tag_n};
            y_valid        <= tags[PIPE_LAT];
            if (tags[PIPE_LAT])
                y_out <= fir_y_n;
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: directed plus randomized command sequences checked
// cycle by cycle against a command-level reference of the controller.
module tb_fir_stream_ctrl;

    localparam int PL = 2;
    localparam int NT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  fir_x_n;
    logic        fir_tvalid;
    logic        fir_set_coeffs;
    logic [13:0] fir_y_n;
    logic [13:0] y_out;
    logic        y_valid;
    logic        busy;

    fir_stream_ctrl #(
        .X_N_SIZE(8), .Y_N_SIZE(14), .NBR_OF_TAPS(NT),
        .INIT_CYCLES(4), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .fir_x_n(fir_x_n), .fir_tvalid(fir_tvalid),
        .fir_set_coeffs(fir_set_coeffs), .fir_y_n(fir_y_n),
        .y_out(y_out), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [13:0] yh [0:4095];
    bit          ex_tag [0:4095];
    logic [7:0]  lastx = 8'h00;
    logic [13:0] ey = 14'h0;
    logic [7:0]  pay [$];
    int          gp [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock: drive inputs, then check the cycle after the edge against
    // the expected strobe/tag/ready/busy values given by the caller.
    task automatic step(input bit v, input logic [7:0] d, input bit tv,
                        input bit sc, input logic [7:0] x, input bit tg,
                        input bit rdy, input bit bsy);
        bit yv;
        cmd_valid = v;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cyc++;
        fir_y_n = 14'($urandom);
        yh[cyc] = fir_y_n;
        if (tv || sc)
            lastx = x;
        ex_tag[cyc] = tg;
        @(negedge clk);
        cmd_valid = 1'b0;
        yv = (cyc > PL) ? ex_tag[cyc-PL-1] : 1'b0;
        if (yv)
            ey = yh[cyc-1];
        chk("cmd_ready", cmd_ready, rdy);
        chk("busy", busy, bsy);
        chk("fir_tvalid", fir_tvalid, tv);
        chk("fir_set_coeffs", fir_set_coeffs, sc);
        chk("fir_x_n", fir_x_n, lastx);
        chk("y_valid", y_valid, yv);
        chk("y_out", y_out, ey);
        chk("strobe_excl", fir_tvalid && fir_set_coeffs, 0);
    endtask

    task automatic rst_step();
        reset = 1'b1;
        for (int i = cyc - PL; i <= cyc; i++)
            if (i >= 0)
                ex_tag[i] = 1'b0;
        lastx = 8'h00;
        ey    = 14'h0;
        step(1'b0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    endtask

    task automatic init_wait();
        repeat (3) step(1'b0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    endtask

    task automatic drain();
        for (int j = 0; j < PL; j++)
            step(1'b0, 8'h00, 1, 0, 8'h00, 0, j == PL - 1, j != PL - 1);
    endtask

    task automatic coef();
        int n;
        n = pay.size();
        step(1'b1, 8'h40 | 8'(n), 0, 0, 8'h00, 0, 1, 1);
        for (int i = 0; i < n; i++) begin
            repeat (gp[i]) step(1'b0, 8'h00, 0, 0, 8'h00, 0, 1, 1);
            step(1'b1, pay[i], 0, 1, pay[i], 0, 1, i != n - 1);
        end
    endtask

    task automatic stream();
        int n;
        n = pay.size();
        step(1'b1, 8'h80 | 8'(n), 0, 0, 8'h00, 0, 1, 1);
        for (int i = 0; i < n; i++) begin
            repeat (gp[i]) step(1'b0, 8'h00, 1, 0, 8'h00, 0, 1, 1);
            step(1'b1, pay[i], 1, 0, pay[i], 1, i != n - 1, 1);
        end
        drain();
    endtask

    task automatic flush(input logic [5:0] len);
        step(1'b1, {2'b11, len}, 0, 0, 8'h00, 0, 0, 1);
        repeat (NT) step(1'b0, 8'h00, 1, 0, 8'h00, 1, 0, 1);
        drain();
    endtask

    task automatic fill(input int n);
        pay.delete();
        gp.delete();
        for (int i = 0; i < n; i++) begin
            pay.push_back(8'($urandom));
            gp.push_back(($urandom_range(0, 3) == 0) ?
                         int'($urandom_range(1, 2)) : 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        fir_y_n   = 14'h0;
        for (int i = 0; i < 4096; i++) begin
            ex_tag[i] = 1'b0;
            yh[i]     = 14'h0;
        end
        @(negedge clk);

        rst_step();
        reset = 1'b1;
        rst_step();
        init_wait();
        idle(2);

        pay = '{8'h05, 8'h3F, 8'h01};
        gp  = '{0, 2, 0};
        coef();
        idle(2);

        pay = '{8'h10, 8'h20, 8'h30, 8'h40};
        gp  = '{0, 0, 0, 0};
        stream();
        idle(PL + 2);

        pay = '{8'h7F, 8'h81};
        gp  = '{0, 3};
        stream();
        idle(PL + 2);

        flush(6'd0);
        step(1'b1, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        idle(PL + 2);

        step(1'b1, 8'h40, 0, 0, 8'h00, 0, 1, 0);
        step(1'b1, 8'h80, 0, 0, 8'h00, 0, 1, 0);

        step(1'b1, 8'h85, 0, 0, 8'h00, 0, 1, 1);
        step(1'b1, 8'hA1, 1, 0, 8'hA1, 1, 1, 1);
        step(1'b1, 8'hB2, 1, 0, 8'hB2, 1, 1, 1);
        rst_step();
        init_wait();
        idle(PL + 3);

        repeat (30) begin
            case ($urandom_range(0, 4))
                0: begin
                    fill(int'($urandom_range(1, 5)));
                    coef();
                end
                1, 2: begin
                    fill(int'($urandom_range(1, 6)));
                    stream();
                end
                3: flush(6'($urandom));
                default:
                    step(1'b1, {2'b00, 6'($urandom)}, 0, 0, 8'h00, 0, 1, 0);
            endcase
            idle(int'($urandom_range(0, 2)));
        end
        idle(PL + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Command-driven sequencer in front of the adaptive-coefficient FIR filter. It accepts a byte stream from the host pin interface, decodes command headers, and drives the FIR's sample, coefficient-load and valid strobes with correct cycle framing. It also waits out the FIR's post-reset setup period and tags FIR outputs so that the host receives exactly one `y_valid` pulse per real input sample.

## Interface
Parameters:
- `X_N_SIZE`, default 8: sample/coefficient byte width; must be 8.
- `Y_N_SIZE`, default 14: FIR output width.
- `NBR_OF_TAPS`, default 10: number of zero samples issued by FLUSH.
- `INIT_CYCLES`, default 4: cycles the FIR needs after reset before it accepts strobes.
- `PIPE_LAT`, default 2, minimum 1: cycles from a sample on `fir_x_n` to its result on `fir_y_n`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `cmd_data`  in  8  host header or payload byte.
- `cmd_valid`  in  1  `cmd_data` is valid.
- `cmd_ready`  out  1  controller accepts `cmd_data` this cycle.
- `fir_x_n`  out  X_N_SIZE  sample or coefficient to the FIR.
- `fir_tvalid`  out  1  FIR streaming strobe.
- `fir_set_coeffs`  out  1  FIR coefficient shift strobe.
- `fir_y_n`  in  Y_N_SIZE  FIR output.
- `y_out`  out  Y_N_SIZE  captured filter result.
- `y_valid`  out  1  `y_out` holds a result for a counted sample; one-cycle pulse.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Handshake: a byte is accepted on a rising edge where `cmd_valid && cmd_ready`. `cmd_ready` is 1 in IDLE, COEF and STREAM, and 0 in WAIT_INIT, FLUSH and DRAIN.
- All outputs are registered. Reset values: `cmd_ready` 0, `fir_x_n` 0, `fir_tvalid` 0, `fir_set_coeffs` 0, `y_out` 0, `y_valid` 0, `busy` 1.
- States: WAIT_INIT, IDLE, COEF, STREAM, FLUSH, DRAIN.
- WAIT_INIT: entered on reset. The controller counts INIT_CYCLES cycles, then moves to IDLE.
- IDLE: the accepted byte is a header. Bits [7:6] are the opcode; bits [5:0] are `len`.
  - `00` NOP: stay in IDLE.
  - `01` LOAD_COEFF: go to COEF with `remaining = len`. If `len = 0`, stay in IDLE.
  - `10` STREAM: go to STREAM with `remaining = len`. If `len = 0`, stay in IDLE.
  - `11` FLUSH: go to FLUSH; `len` is ignored.
- COEF: each accepted byte drives `fir_x_n = byte` and `fir_set_coeffs = 1` for exactly the following cycle, then decrements `remaining`. While no byte is accepted, `fir_set_coeffs = 0` and `fir_x_n` holds its value. The last byte returns the block to IDLE. `fir_tvalid` is 0 throughout COEF.
- STREAM: `fir_tvalid = 1` for every cycle in STREAM, and stays 1 through DRAIN.
  - An accepted byte drives `fir_x_n = byte`, decrements `remaining` and is counted (pushes a tag).
  - A cycle with no accepted byte drives `fir_x_n = 0` and is not counted (no tag).
  - The last counted byte moves the block to DRAIN.
- FLUSH: drives NBR_OF_TAPS consecutive cycles with `fir_tvalid = 1` and `fir_x_n = 0`. Each of these cycles is counted. Then the block moves to DRAIN.
- DRAIN: drives PIPE_LAT cycles with `fir_tvalid = 1` and `fir_x_n = 0`, uncounted. Then the block goes to IDLE, and `fir_tvalid` drops to 0 on the IDLE cycle.
- Tag pipe: a PIPE_LAT-deep shift register of 1-bit tags.
  - If a counted sample is on `fir_x_n` in cycle t, then at the end of cycle t+PIPE_LAT the controller registers `fir_y_n` into `y_out`.
  - `y_valid` is 1 in cycle t+PIPE_LAT+1.
  - `y_out` holds its value when there is no tag.
- `fir_set_coeffs` and `fir_tvalid` are never 1 in the same cycle.
- Reset mid-operation: on the next edge all outputs take their reset values, the tag pipe and counters clear, and the state becomes WAIT_INIT. A partially received command is discarded.
- `busy` is 0 only in IDLE.

## Timing
- A header accepted at edge k changes the state at edge k; the first payload byte can be accepted at edge k+1.
- A payload byte accepted at edge m appears on `fir_x_n` and its strobe during cycle m→m+1.
- Back-to-back STREAM bytes give one sample per cycle with no zero insertion.
- Sample-to-`y_valid` latency: PIPE_LAT+1 cycles after the sample's `fir_x_n` cycle.
- DRAIN has a fixed length of PIPE_LAT cycles. IDLE can accept a new header in the first cycle after DRAIN.
- The last LOAD_COEFF byte's strobe cycle overlaps the first IDLE cycle. A header accepted in that cycle is legal.
- Clock/reset: a single rising-edge domain.

## Test plan
- **Reset/init:** assert reset for 2 cycles, then release.
  - Required: `cmd_ready = 0` and `busy = 1` for exactly INIT_CYCLES = 4 cycles, then `cmd_ready = 1` and `busy = 0`.
  - All FIR strobes stay 0 throughout.
- **LOAD_COEFF 3:** send header 0x43 followed by bytes 0x05, 0x3F, 0x01 with a 2-cycle gap after the first byte.
  - Required: exactly 3 single-cycle `fir_set_coeffs` pulses, carrying 0x05, 0x3F, 0x01.
  - `fir_tvalid` stays 0 and the block is back in IDLE after the third byte.
- **STREAM 4, back-to-back:** send header 0x84 followed by 0x10, 0x20, 0x30, 0x40.
  - Required: `fir_tvalid` is high for 4+PIPE_LAT = 6 cycles.
  - Exactly 4 `y_valid` pulses, each PIPE_LAT+1 = 3 cycles after its sample, with `y_out` equal to `fir_y_n` from the model.
- **STREAM with gap:** send header 0x82 followed by 0x7F, a 3-cycle stall, then 0x81.
  - Required: `fir_x_n` is 0 during the 3 gap cycles while `fir_tvalid` stays 1.
  - Exactly 2 `y_valid` pulses.
- **FLUSH and NOP:** send header 0xC0 followed by 0x00.
  - Required: 10 counted zero cycles, then 2 drain cycles, then 10 `y_valid` pulses.
  - The NOP produces no strobes and leaves `busy = 0`.
- **Reset mid-STREAM:** after 2 of 5 samples, assert reset.
  - Required: on the next edge all outputs take their reset values and no further `y_valid` pulses appear.
  - A WAIT_INIT of 4 cycles follows.
